frequency_measure_controller: RTL and testbench

Sequencer for the `frequency_analyzer` datapath. It clears the analyzer, then enables it for a fixed measurement window of clock cycles. At the end of the window it freezes and captures the two accumulated tick counts. It classifies the tone (FREQUENCY_1 vs FREQUENCY_2, or no signal) and presents the result on a valid/ready handshake, in single-shot or continuous mode.

---
 rtl/frequency_measure_controller.sv | 141 ++++++++++++++
 tb/tb_frequency_measure_controller.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/frequency_measure_controller.sv
// frequency_measure_controller
// Sequencer for the frequency_analyzer datapath: clears the analyzer, enables
// it for a fixed window, freezes it, captures both tick totals, classifies the
// tone and presents the result on a valid/ready handshake.
module frequency_measure_controller #(
  parameter int unsigned CLOCK        = 50_000_000,
  parameter int unsigned WINDOW_TICKS = 500_000,
  parameter int unsigned MIN_TICKS    = 1000
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  output logic        analyzer_enable,
  output logic        analyzer_clear,
  input  logic [31:0] f1_value,
  input  logic [31:0] f2_value,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        result_tone,
  output logic        result_no_signal,
  output logic [31:0] result_f1,
  output logic [31:0] result_f2,
  output logic        busy
);

  // Counter wide enough to hold WINDOW_TICKS-1 (WINDOW_TICKS >= 2 keeps CW >= 1)
  localparam int unsigned    CW       = $clog2(WINDOW_TICKS);
  localparam logic [CW-1:0]  LAST     = CW'(WINDOW_TICKS - 1);
  localparam logic [32:0]    MIN_SUM  = 33'(MIN_TICKS);

  // Reject parameter sets that cannot produce a meaningful window
  if (WINDOW_TICKS < 2 || CLOCK == 0) begin : g_param_check
    $error("frequency_measure_controller: WINDOW_TICKS must be >= 2 and CLOCK nonzero");
  end

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    MEASURE,
    SETTLE,
    CAPTURE,
    REPORT
  } state_t;

  state_t        state;
  logic [CW-1:0] win_cnt;
  logic [32:0]   sum;
  logic          no_signal_next;
  logic          tone_next;

  // Classification of the frozen analyzer totals, full 33-bit sum
  always_comb begin
    sum            = {1'b0, f1_value} + {1'b0, f2_value};
    no_signal_next = (sum < MIN_SUM);
    tone_next      = !no_signal_next && (f2_value > f1_value);
  end

  // Sequencer FSM; every output is registered and set on the transition
  // into the state that owns it, so outputs depend only on flops
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state            <= IDLE;
      win_cnt          <= '0;
      analyzer_enable  <= 1'b0;
      analyzer_clear   <= 1'b0;
      result_valid     <= 1'b0;
      result_tone      <= 1'b0;
      result_no_signal <= 1'b0;
      result_f1        <= '0;
      result_f2        <= '0;
      busy             <= 1'b0;
    end else if (abort) begin
      // Abort wins over start and the handshake; captured results are kept
      state           <= IDLE;
      analyzer_enable <= 1'b0;
      analyzer_clear  <= 1'b0;
      result_valid    <= 1'b0;
      busy            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state           <= CLR;
            win_cnt         <= '0;
            analyzer_enable <= 1'b1;
            analyzer_clear  <= 1'b1;
            busy            <= 1'b1;
          end
        end
        CLR: begin
          state          <= MEASURE;
          win_cnt        <= '0;
          analyzer_clear <= 1'b0;
        end
        MEASURE: begin
          if (win_cnt == LAST) begin
            state           <= SETTLE;
            analyzer_enable <= 1'b0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        SETTLE: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          state            <= REPORT;
          result_f1        <= f1_value;
          result_f2        <= f2_value;
          result_no_signal <= no_signal_next;
          result_tone      <= tone_next;
          result_valid     <= 1'b1;
        end
        REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            if (continuous) begin
              state           <= CLR;
              win_cnt         <= '0;
              analyzer_enable <= 1'b1;
              analyzer_clear  <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state           <= IDLE;
          analyzer_enable <= 1'b0;
          analyzer_clear  <= 1'b0;
          result_valid    <= 1'b0;
          busy            <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frequency_measure_controller.sv
// Self-checking bench for frequency_measure_controller.
module tb_frequency_measure_controller;

  localparam int unsigned W   = 1000;
  localparam int unsigned MIN = 1000;

  logic        clock = 1'b0;
  logic        clear;
  logic        start;
  logic        continuous;
  logic        abort;
  logic        analyzer_enable;
  logic        analyzer_clear;
  logic [31:0] f1_value;
  logic [31:0] f2_value;
  logic        result_valid;
  logic        result_ready;
  logic        result_tone;
  logic        result_no_signal;
  logic [31:0] result_f1;
  logic [31:0] result_f2;
  logic        busy;

  logic [31:0] tgt_f1;
  logic [31:0] tgt_f2;

  int vectors     = 0;
  int miscompares = 0;
  int en_cycles   = 0;
  int clr_cycles  = 0;

  frequency_measure_controller #(
    .CLOCK        (50_000_000),
    .WINDOW_TICKS (W),
    .MIN_TICKS    (MIN)
  ) dut (
    .clock            (clock),
    .clear            (clear),
    .start            (start),
    .continuous       (continuous),
    .abort            (abort),
    .analyzer_enable  (analyzer_enable),
    .analyzer_clear   (analyzer_clear),
    .f1_value         (f1_value),
    .f2_value         (f2_value),
    .result_valid     (result_valid),
    .result_ready     (result_ready),
    .result_tone      (result_tone),
    .result_no_signal (result_no_signal),
    .result_f1        (result_f1),
    .result_f2        (result_f2),
    .busy             (busy)
  );

  always #5 clock = ~clock;

  // Analyzer stand-in: totals are only meaningful once the analyzer is frozen
  assign f1_value = analyzer_enable ? (tgt_f1 ^ 32'hA5A5_5A5A) : tgt_f1;
  assign f2_value = analyzer_enable ? (tgt_f2 ^ 32'h3C3C_C3C3) : tgt_f2;

  // Count cycles with enable / clear high
  always @(posedge clock) begin
    if (analyzer_enable) en_cycles++;
    if (analyzer_clear)  clr_cycles++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference classification from plain arithmetic
  function automatic void ref_classify(input logic [31:0] a, input logic [31:0] b,
                                       output logic tone, output logic nos);
    longint unsigned s;
    s    = longint'(a) + longint'(b);
    nos  = (s < longint'(MIN));
    tone = !nos && (b > a);
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Edges until result_valid, bounded
  task automatic wait_valid(output int n);
    n = 0;
    while (!result_valid && n < 2 * W + 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] a, input logic [31:0] b);
    logic et, en;
    ref_classify(a, b, et, en);
    check({tag, "_f1"},   64'(result_f1), 64'(a));
    check({tag, "_f2"},   64'(result_f2), 64'(b));
    check({tag, "_tone"}, 64'(result_tone), 64'(et));
    check({tag, "_nos"},  64'(result_no_signal), 64'(en));
  endtask

  task automatic accept(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_valid_drop"}, 64'(result_valid), 64'd0);
    check({tag, "_busy_drop"},  64'(busy), 64'd0);
  endtask

  task automatic run_one(input string tag, input logic [31:0] a, input logic [31:0] b);
    int e0, c0, n;
    tgt_f1 = a;
    tgt_f2 = b;
    e0 = en_cycles;
    c0 = clr_cycles;
    do_start();
    check({tag, "_clr_pulse"}, 64'(analyzer_clear), 64'd1);
    check({tag, "_busy"},      64'(busy), 64'd1);
    wait_valid(n);
    check({tag, "_latency"},   64'(n), 64'(W + 3));
    check({tag, "_en_cycles"}, 64'(en_cycles - e0), 64'(W + 1));
    check({tag, "_clr_cycles"},64'(clr_cycles - c0), 64'd1);
    check_result(tag, a, b);
    accept(tag);
  endtask

  initial begin
    int n;
    logic seen;
    logic [31:0] a, b, hf1, hf2;
    logic ht, hn;

    clear = 1'b1; start = 1'b0; continuous = 1'b0; abort = 1'b0; result_ready = 1'b0;
    tgt_f1 = '0; tgt_f2 = '0;
    #12;
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_enable", 64'(analyzer_enable), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    tick();
    clear = 1'b0;
    repeat (3) tick();
    check("rst_idle_busy", 64'(busy), 64'd0);

    // Directed classification cases
    run_one("single", 32'd700, 32'd200);
    run_one("tone2", 32'd100, 32'd950);
    run_one("thresh", 32'd400, 32'd500);
    run_one("tie", 32'd600, 32'd600);
    run_one("wide", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Randomized totals: near the threshold and full range
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        a = $urandom_range(0, 1200);
        b = $urandom_range(0, 1200);
      end else begin
        a = $urandom;
        b = $urandom;
      end
      run_one($sformatf("rand%0d", i), a, b);
    end

    // Backpressure with continuous mode
    continuous = 1'b1;
    tgt_f1 = 32'd1234; tgt_f2 = 32'd5678;
    do_start();
    wait_valid(n);
    check("bp_latency", 64'(n), 64'(W + 3));
    tgt_f1 = 32'd11; tgt_f2 = 32'd22;
    for (int i = 0; i < 50; i++) begin
      tick();
      check("bp_valid_hold", 64'(result_valid), 64'd1);
      check("bp_f1_hold", 64'(result_f1), 64'd1234);
      check("bp_f2_hold", 64'(result_f2), 64'd5678);
    end
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    continuous = 1'b0;
    check("cont_clear", 64'(analyzer_clear), 64'd1);
    check("cont_valid_drop", 64'(result_valid), 64'd0);
    check("cont_busy", 64'(busy), 64'd1);
    tgt_f1 = 32'd3000; tgt_f2 = 32'd4000;
    wait_valid(n);
    check("cont_latency", 64'(n), 64'(W + 3));
    check_result("cont", 32'd3000, 32'd4000);
    accept("cont");

    // Start pulses mid-window are ignored
    tgt_f1 = 32'd2000; tgt_f2 = 32'd10;
    do_start();
    repeat (100) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (20) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_valid(n);
    check("ign_start_latency", 64'(n), 64'(W + 3 - 122));
    check_result("ign_start", 32'd2000, 32'd10);

    // Abort in REPORT: valid drops, captured values kept
    hf1 = result_f1; hf2 = result_f2;
    abort = 1'b1; result_ready = 1'b1;
    tick();
    abort = 1'b0; result_ready = 1'b0;
    check("abort_rep_valid", 64'(result_valid), 64'd0);
    check("abort_rep_busy", 64'(busy), 64'd0);
    check("abort_rep_f1_kept", 64'(result_f1), 64'(hf1));
    check("abort_rep_f2_kept", 64'(result_f2), 64'(hf2));

    // Abort in MEASURE: back to IDLE, no result ever appears
    do_start();
    repeat (50) tick();
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_meas_enable", 64'(analyzer_enable), 64'd0);
    check("abort_meas_busy", 64'(busy), 64'd0);
    seen = 1'b0;
    for (int i = 0; i < W + 100; i++) begin
      tick();
      if (result_valid || busy) seen = 1'b1;
    end
    check("abort_meas_no_result", 64'(seen), 64'd0);

    // Abort beats start in IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check("abort_over_start", 64'(busy), 64'd0);

    // Asynchronous clear mid-window
    ref_classify(32'd5, 32'd5, ht, hn);
    run_one("pre_rst", 32'd900, 32'd5);
    do_start();
    repeat (20) tick();
    #2 clear = 1'b1;
    #1;
    check("async_enable", 64'(analyzer_enable), 64'd0);
    check("async_busy", 64'(busy), 64'd0);
    check("async_f1", 64'(result_f1), 64'd0);
    check("async_tone", 64'(result_tone), 64'(ht));
    check("async_nos", 64'(result_no_signal), 64'd0);
    tick();
    clear = 1'b0;
    repeat (5) tick();
    check("post_rst_idle", 64'(busy), 64'd0);
    check("post_rst_enable", 64'(analyzer_enable), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
